// File: rtl/keypad_pkg.sv
// Shared types, key map and bit-count helpers for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic {
        RELEASED,
        HELD
    } key_state_e;

    typedef enum logic [1:0] {
        CNT_ZERO,
        CNT_ONE,
        CNT_MANY
    } bit_count_e;

    // Hex code per key, indexed row*4+col (Pmod KYPD layout).
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // Classifies a 16-bit key state as no key, one key or several keys.
    function automatic bit_count_e count_class(input logic [15:0] bits);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            n += 32'(bits[i]);
        end
        if (n == 0) return CNT_ZERO;
        else if (n == 1) return CNT_ONE;
        else return CNT_MANY;
    endfunction

    // Snapshot bits are laid out col*4+row; the key map is row*4+col.
    function automatic logic [3:0] key_lookup(input logic [15:0] bits);
        logic [3:0] code;
        logic [3:0] idx;
        code = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (bits[i]) begin
                idx  = 4'(((i % 4) * 4) + (i / 4));
                code = KEY_MAP[idx];
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event handshake between the keypad scanner and its consumer.
interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overrun,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun,
        output key_ready
    );
endinterface

// File: rtl/keypad_col_scan.sv
// Column sequencer: drives one active-low column per SCAN_DIV cycles and
// strobes the row sample point and the end of each full scan.
module keypad_col_scan #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] col_n,
    output logic [1:0] col,
    output logic       sample_stb,
    output logic       scan_end
);
    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div_cnt;

    // Column period counter and column index advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            col     <= '0;
        end else if (sample_stb) begin
            div_cnt <= '0;
            col     <= col + 2'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Strobes on the last cycle of a column; column drive decoded from index.
    always_comb begin
        sample_stb = (div_cnt == DIV_W'(SCAN_DIV - 1));
        scan_end   = sample_stb && (col == 2'd3);
        col_n      = ~(4'b0001 << col);
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: synchronizes rows, builds full-scan snapshots,
// debounces them, turns single-key presses into events and buffers one event.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [3:0]       col_n,
    input  logic [3:0]       row_n,
    keypad_scanner_if.master kbus
);
    localparam int               CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [1:0]       col;
    logic             sample_stb;
    logic             scan_end;
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [15:0]      snap;
    logic [15:0]      snap_next;
    logic [15:0]      prev_snap;
    logic [15:0]      debounced;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             deb_pulse;
    key_state_e       state;
    key_state_e       state_next;
    bit_count_e       deb_class;
    logic             emit;
    logic [3:0]       code_q;
    logic             valid_q;
    logic             overrun_q;
    logic             xfer;

    keypad_col_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_col_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_n      (col_n),
        .col        (col),
        .sample_stb (sample_stb),
        .scan_end   (scan_end)
    );

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Snapshot with the current column's rows merged in, and the next stable count.
    always_comb begin
        snap_next = snap;
        snap_next[{col, 2'b00} +: 4] = ~row_sync;
        if (snap_next == prev_snap) begin
            cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
        end else begin
            cnt_next = CNT_W'(1);
        end
    end

    // Snapshot capture and scan-to-scan debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap       <= '0;
            prev_snap  <= '0;
            debounced  <= '0;
            stable_cnt <= '0;
            deb_pulse  <= 1'b0;
        end else begin
            deb_pulse <= 1'b0;
            if (sample_stb) begin
                snap <= snap_next;
            end
            if (scan_end) begin
                prev_snap  <= snap_next;
                stable_cnt <= cnt_next;
                if (cnt_next == CNT_MAX) begin
                    debounced <= snap_next;
                    deb_pulse <= 1'b1;
                end
            end
        end
    end

    assign deb_class = count_class(debounced);

    // Event FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RELEASED;
        end else begin
            state <= state_next;
        end
    end

    // Event FSM: one event per isolated press, lockout on multi-key, rearm on full release.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        if (deb_pulse) begin
            case (state)
                RELEASED: begin
                    if (deb_class == CNT_ONE) begin
                        emit       = 1'b1;
                        state_next = HELD;
                    end else if (deb_class == CNT_MANY) begin
                        state_next = HELD;
                    end
                end
                HELD: begin
                    if (deb_class == CNT_ZERO) begin
                        state_next = RELEASED;
                    end
                end
                default: state_next = RELEASED;
            endcase
        end
    end

    assign xfer = valid_q & kbus.key_ready;

    // One-entry output buffer; the event branch follows the transfer branch so a
    // same-cycle event reloads the entry instead of leaving it cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (xfer) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (emit) begin
                if (!valid_q || xfer) begin
                    code_q  <= key_lookup(debounced);
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign kbus.key_code  = code_q;
    assign kbus.key_valid = valid_q;
    assign kbus.overrun   = overrun_q;
    assign kbus.key_held  = (state == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad model.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] pressed = '0;   // bench layout: bit r*4+c

    int n_tests = 0;
    int n_fail  = 0;
    int n_rise  = 0;
    logic valid_d = 1'b0;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV       (8),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .col_n (col_n),
        .row_n (row_n),
        .kbus  (kif)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key shorts its row to the driven (low) column.
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
        end
    end

    // Count key_valid rising edges to detect extra or missing events.
    always @(posedge clk) begin
        valid_d <= kif.key_valid;
        if (kif.key_valid && !valid_d) n_rise <= n_rise + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sel 0 = key_valid, 1 = key_held; polls on falling edges with a cycle bound.
    task automatic wait_for(input int sel, input logic lvl, input int max_cyc, output bit ok);
        logic cur;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            cur = (sel == 0) ? kif.key_valid : kif.key_held;
            if (cur == lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int r0;
        kif.key_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col_n", 32'(col_n), 32'h0000_000E);
        check("rst_valid", 32'(kif.key_valid), 0);
        check("rst_code", 32'(kif.key_code), 0);
        check("rst_held", 32'(kif.key_held), 0);
        check("rst_overrun", 32'(kif.overrun), 0);
        rst_n = 1'b1;

        // A: single press row0/col1 with ready high
        kif.key_ready = 1'b1;
        r0 = n_rise;
        pressed = 16'h0002;
        wait_for(0, 1'b1, 96, ok);
        check("A_valid_seen", 32'(ok), 1);
        check("A_code", 32'(kif.key_code), 32'h2);
        @(negedge clk);
        check("A_pulse_1cyc", 32'(kif.key_valid), 0);
        check("A_held", 32'(kif.key_held), 1);
        pressed = '0;
        repeat (30) @(negedge clk);
        check("A_held_after_rel", 32'(kif.key_held), 1);
        wait_for(1, 1'b0, 100, ok);
        check("A_release", 32'(ok), 1);
        check("A_events", 32'(n_rise - r0), 1);

        // B: hold row3/col1 with ready low, then drop an event for C
        kif.key_ready = 1'b0;
        r0 = n_rise;
        pressed = 16'h2000;
        wait_for(0, 1'b1, 130, ok);
        check("B_valid_seen", 32'(ok), 1);
        check("B_code", 32'(kif.key_code), 32'hF);
        repeat (64) @(negedge clk);
        check("B_valid_hold", 32'(kif.key_valid), 1);
        check("B_code_hold", 32'(kif.key_code), 32'hF);
        pressed = '0;
        wait_for(1, 1'b0, 130, ok);
        check("B_release", 32'(ok), 1);
        pressed = 16'h0800;
        wait_for(1, 1'b1, 130, ok);
        check("B_c_held", 32'(ok), 1);
        check("B_overrun_set", 32'(kif.overrun), 1);
        check("B_code_kept", 32'(kif.key_code), 32'hF);
        check("B_valid_kept", 32'(kif.key_valid), 1);
        kif.key_ready = 1'b1;
        @(negedge clk);
        kif.key_ready = 1'b0;
        check("B_valid_clr", 32'(kif.key_valid), 0);
        check("B_overrun_clr", 32'(kif.overrun), 0);
        check("B_events", 32'(n_rise - r0), 1);
        pressed = '0;
        wait_for(1, 1'b0, 130, ok);
        check("B_release_c", 32'(ok), 1);

        // C: two keys together lock out, then a single press of 9
        kif.key_ready = 1'b1;
        r0 = n_rise;
        pressed = 16'h0030;
        wait_for(1, 1'b1, 130, ok);
        check("C_multi_held", 32'(ok), 1);
        repeat (40) @(negedge clk);
        check("C_multi_held_stay", 32'(kif.key_held), 1);
        check("C_multi_no_event", 32'(n_rise - r0), 0);
        pressed = '0;
        wait_for(1, 1'b0, 130, ok);
        check("C_multi_release", 32'(ok), 1);
        pressed = 16'h0400;
        wait_for(0, 1'b1, 130, ok);
        check("C_valid_seen", 32'(ok), 1);
        check("C_code", 32'(kif.key_code), 32'h9);
        pressed = '0;
        wait_for(1, 1'b0, 130, ok);
        check("C_release", 32'(ok), 1);

        // D: chatter on row0/col0 for five scans, then steady
        r0 = n_rise;
        for (int i = 0; i < 5; i++) begin
            pressed[0] = ~pressed[0];
            repeat (32) @(negedge clk);
        end
        check("D_no_chatter_event", 32'(n_rise - r0), 0);
        wait_for(0, 1'b1, 100, ok);
        check("D_valid_seen", 32'(ok), 1);
        check("D_code", 32'(kif.key_code), 32'h1);
        repeat (64) @(negedge clk);
        check("D_one_event", 32'(n_rise - r0), 1);
        pressed = '0;
        wait_for(1, 1'b0, 130, ok);
        check("D_release", 32'(ok), 1);

        // E: new event lands in the same cycle as a handshake
        kif.key_ready = 1'b0;
        pressed = 16'h0100;
        wait_for(0, 1'b1, 130, ok);
        check("E_valid_seen", 32'(ok), 1);
        check("E_code7", 32'(kif.key_code), 32'h7);
        pressed = '0;
        wait_for(1, 1'b0, 130, ok);
        check("E_release", 32'(ok), 1);
        pressed = 16'h0200;
        repeat (63) @(negedge clk);
        check("E_pending", 32'(kif.key_code), 32'h7);
        kif.key_ready = 1'b1;
        @(negedge clk);
        kif.key_ready = 1'b0;
        check("E_valid_stays", 32'(kif.key_valid), 1);
        check("E_code8", 32'(kif.key_code), 32'h8);
        check("E_no_overrun", 32'(kif.overrun), 0);
        pressed = '0;
        wait_for(1, 1'b0, 130, ok);
        check("E_release8", 32'(ok), 1);
        kif.key_ready = 1'b1;
        @(negedge clk);

        // F: asynchronous reset mid-scan with an event pending, key held through it
        kif.key_ready = 1'b0;
        pressed = 16'h0004;
        wait_for(0, 1'b1, 130, ok);
        check("F_valid_seen", 32'(ok), 1);
        check("F_code", 32'(kif.key_code), 32'h3);
        repeat (13) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("F_rst_valid", 32'(kif.key_valid), 0);
        check("F_rst_code", 32'(kif.key_code), 0);
        check("F_rst_held", 32'(kif.key_held), 0);
        check("F_rst_overrun", 32'(kif.overrun), 0);
        check("F_rst_col_n", 32'(col_n), 32'h0000_000E);
        r0 = n_rise;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        wait_for(0, 1'b1, 130, ok);
        check("F_after_rst_seen", 32'(ok), 1);
        check("F_after_rst_code", 32'(kif.key_code), 32'h3);
        kif.key_ready = 1'b1;
        repeat (100) @(negedge clk);
        check("F_one_event", 32'(n_rise - r0), 1);
        pressed = '0;
        wait_for(1, 1'b0, 130, ok);
        check("F_release", 32'(ok), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad (Pmod KYPD layout) and delivers debounced key-press events as 4-bit hex codes over a valid/ready handshake. It is the input-side counterpart of the multiplexed seven-segment driver: it drives one active-low column at a time and reads the row lines. It sits at the board top level between the keypad pins and the CPU or other consumer logic.

## Interface
Parameters:
- SCAN_DIV, 100_000: clk cycles each column is driven; must be >= 4.
- DEBOUNCE_SCANS, 4: number of consecutive identical full-scan snapshots required to accept a new key state; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- col_n  out  4  column drive; exactly one bit is low at any time.
- row_n  in  4  row sense; active-low, externally pulled up, asynchronous to clk.
- key_code  out  4  hex value of the pressed key; held stable while key_valid=1.
- key_valid  out  1  event available.
- key_ready  in  1  consumer accepts the event.
- key_held  out  1  debounced state is non-empty and an event (or a multi-key lockout) is in progress.
- overrun  out  1  sticky flag: an event was dropped because the buffer was full.

## Operation
- row_n passes through a 2-FF synchronizer before any use.
- Column sequencer:
  - col index counts 0→1→2→3→0; col_n = ~(1<<col).
  - Each column is driven for SCAN_DIV cycles.
  - On the last cycle of each column period, the synchronized ~row_n[3:0] is written into snapshot bits [col*4+3 : col*4] (bit index = col*4+row).
- Scan completion:
  - At the end of column 3, the full snapshot is compared with the previous full snapshot.
  - If they are equal, stable_cnt increments, saturating at DEBOUNCE_SCANS. Otherwise stable_cnt = 1.
  - When stable_cnt reaches DEBOUNCE_SCANS, the debounced state is set to the snapshot.
- Key map, index row*4+col:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- Event FSM, evaluated on each debounced update:
  - RELEASED, exactly one bit set: emit an event, go to HELD.
  - RELEASED, two or more bits set: go to HELD with no event (multi-key lockout).
  - HELD, zero bits set: go to RELEASED.
  - All other cases: stay in the current state.
  - key_held = (state==HELD).
  - A second key pressed while in HELD produces no event. An event fires only after a full release.
- Output buffer (one entry):
  - An event with key_valid=0 loads key_code and sets key_valid.
  - key_valid & key_ready in a cycle completes a transfer: key_valid clears and overrun clears.
  - An event with key_valid=1 and key_ready=0 is dropped; key_code is unchanged and overrun is set.
  - An event in the same cycle as a transfer loads the new code; key_valid stays 1 and there is no overrun.
- Reset values:
  - col index 0, col_n=4'b1110.
  - Snapshots and debounced state 0, stable_cnt 0.
  - FSM RELEASED.
  - key_code=0, key_valid=0, key_held=0, overrun=0.
- A reset mid-scan or mid-event discards all state. A key held through reset emits one event after DEBOUNCE_SCANS scans.

## Timing
- One column period = SCAN_DIV cycles. One full scan = 4*SCAN_DIV cycles.
- The row sample is taken SCAN_DIV-1 cycles after the column switch, which leaves settling time plus the 2-cycle synchronizer delay.
- Let scan k be the first scan in which a press is fully visible:
  - The debounced update occurs on the last cycle of scan k+DEBOUNCE_SCANS-1.
  - key_valid rises 1 cycle later.
- A release is detected with the same latency.
- key_valid and key_code are registered outputs and do not depend combinationally on key_ready.
- key_ready is sampled only while key_valid=1.

## Structure
- Package keypad_pkg contains:
  - typedef enum {RELEASED, HELD} for the FSM.
  - KEY_MAP constant: a 16-entry array of logic[3:0].
  - A popcount-class helper function returning a zero/one/many indication for 16 bits.
- Sub-module keypad_col_scan contains the SCAN_DIV counter, the col index, col_n drive, and the sample strobe and end-of-scan strobe. The snapshot, debounce, FSM and buffer logic stay in the top module.

## Test plan
Bench conditions: SCAN_DIV=8, DEBOUNCE_SCANS=2. The keypad model pulls row_n[r] low while col_n[c]=0 and key (r,c) is pressed.
- Press row0/col1 with key_ready=1:
  - key_valid pulses for 1 cycle with key_code=4'h2, within 3 scans (96 cycles).
  - key_held=1 until the key is released plus 2 scans.
- Press row3/col1 and hold with key_ready=0:
  - key_valid stays 1 with key_code=4'hF until ready is asserted.
  - Release then press row2/col3: the event for C is dropped and overrun=1; key_code is still F.
  - Asserting key_ready clears overrun.
- Press row1/col0 and row1/col1 together: no key_valid and key_held=1. After release, a single press of row2/col2 yields 4'h9.
- Chatter: toggle row0/col0 every scan for 5 scans, then hold steady: exactly one event with code 4'h1, and only after 2 stable scans.
- Assert rst_n low mid-scan with key_valid=1:
  - All outputs return to reset values asynchronously and col_n=4'b1110.
  - A key held through reset produces exactly one event after release from reset.
- Same-cycle event and handshake: the new code is loaded, key_valid remains 1, and overrun stays 0.
